// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath slice: PC, IR, R0 and R1 share one internal bus.
// Bus and conflict flag are combinational; all registers update on the rising clock.
module cpu_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             pci,
    input  logic             pco,
    input  logic             iri,
    input  logic             iro,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_immediate,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] ir_immediate,
    input  logic             r0i,
    input  logic             r0o,
    input  logic             r1i,
    input  logic             r1o,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] ir_q,
    output logic [WIDTH-1:0] r0_q,
    output logic [WIDTH-1:0] r1_q,
    output logic             bus_conflict
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ir_d;
    logic [WIDTH-1:0] r0_d;
    logic [WIDTH-1:0] r1_d;
    logic [2:0]       drive_count;

    // Fixed source priority so a conflict still yields a defined bus value
    always_comb begin
        bus = '0;
        if (pco) begin
            bus = pc_q;
        end else if (iro) begin
            bus = ir_q;
        end else if (r0o) begin
            bus = r0_q;
        end else if (r1o) begin
            bus = r1_q;
        end
    end

    always_comb begin
        drive_count  = 3'(pco) + 3'(iro) + 3'(r0o) + 3'(r1o);
        bus_conflict = (drive_count > 3'd1);
    end

    // clear overrides every load strobe in the same cycle
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        r0_d = r0_q;
        r1_d = r1_q;
        if (clear) begin
            pc_d = pc;
            ir_d = ir;
            r0_d = '0;
            r1_d = '0;
        end else begin
            if (pci) pc_d = pc_immediate;
            if (iri) ir_d = ir_immediate;
            if (r0i) r0_d = bus;
            if (r1i) r1_d = bus;
        end
    end

    always_ff @(posedge clock) begin
        pc_q <= pc_d;
        ir_q <= ir_d;
        r0_q <= r0_d;
        r1_q <= r1_d;
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized strobes
// checked against a register-file reference model.
module tb_cpu_datapath;

    localparam int unsigned WIDTH = 32;

    logic             clock = 1'b0;
    logic             clear, pci, pco, iri, iro, r0i, r0o, r1i, r1o;
    logic [WIDTH-1:0] pc, pc_immediate, ir, ir_immediate;
    logic [WIDTH-1:0] bus, pc_q, ir_q, r0_q, r1_q;
    logic             bus_conflict;

    int tests = 0;
    int fails = 0;

    // Reference register file: index 0=PC 1=IR 2=R0 3=R1
    logic [WIDTH-1:0] m_reg [4];

    always #5 clock = ~clock;

    cpu_datapath #(.WIDTH(WIDTH)) dut (
        .clock(clock), .clear(clear),
        .pci(pci), .pco(pco), .iri(iri), .iro(iro),
        .pc(pc), .pc_immediate(pc_immediate), .ir(ir), .ir_immediate(ir_immediate),
        .r0i(r0i), .r0o(r0o), .r1i(r1i), .r1o(r1o),
        .bus(bus), .pc_q(pc_q), .ir_q(ir_q), .r0_q(r0_q), .r1_q(r1_q),
        .bus_conflict(bus_conflict)
    );

    function automatic logic [WIDTH-1:0] model_bus();
        logic en [4];
        en[0] = pco; en[1] = iro; en[2] = r0o; en[3] = r1o;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) return m_reg[i];
        end
        return '0;
    endfunction

    function automatic logic model_conflict();
        return ($countones({pco, iro, r0o, r1o}) > 1);
    endfunction

    // Advance the model with the pre-edge values, then clock the DUT
    task automatic tick();
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] nxt [4];
        b = model_bus();
        nxt = m_reg;
        if (clear) begin
            nxt[0] = pc; nxt[1] = ir; nxt[2] = '0; nxt[3] = '0;
        end else begin
            if (pci) nxt[0] = pc_immediate;
            if (iri) nxt[1] = ir_immediate;
            if (r0i) nxt[2] = b;
            if (r1i) nxt[3] = b;
        end
        m_reg = nxt;
        @(posedge clock);
        #1;
    endtask

    task automatic strobes(input logic a_pci, a_pco, a_iri, a_iro, a_r0i, a_r0o, a_r1i, a_r1o);
        pci = a_pci; pco = a_pco; iri = a_iri; iro = a_iro;
        r0i = a_r0i; r0o = a_r0o; r1i = a_r1i; r1o = a_r1o;
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; pc = 32'h100; ir = 32'hDEAD_BEEF;
        strobes(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clear = 1'b0;
        #1;
        tests += 5;
        if (pc_q !== 32'h100) begin fails++; $display("FAIL reset_pc: got %h exp %h", pc_q, 32'h100); end
        if (ir_q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL reset_ir: got %h exp %h", ir_q, 32'hDEAD_BEEF); end
        if (r0_q !== 32'h0 || r1_q !== 32'h0) begin fails++; $display("FAIL reset_r: got %h %h exp 0 0", r0_q, r1_q); end
        if (bus !== 32'h0) begin fails++; $display("FAIL reset_bus: got %h exp 0", bus); end
        if (bus_conflict !== 1'b0) begin fails++; $display("FAIL reset_conflict: got %b exp 0", bus_conflict); end
    endtask

    task automatic test_pc_to_r0();
        pc_immediate = 32'd5;
        strobes(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        strobes(0, 1, 0, 0, 1, 0, 0, 0);
        tests += 3;
        if (bus !== 32'd5) begin fails++; $display("FAIL pc_bus: got %h exp %h", bus, 32'd5); end
        tick();
        if (r0_q !== 32'd5) begin fails++; $display("FAIL pc_r0: got %h exp %h", r0_q, 32'd5); end
        if (pc_q !== 32'd5) begin fails++; $display("FAIL pc_hold: got %h exp %h", pc_q, 32'd5); end
    endtask

    task automatic test_ir_transfer();
        ir_immediate = 32'h2891_8000;
        strobes(0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        strobes(0, 0, 0, 1, 0, 0, 1, 0);
        tick();
        tests += 2;
        if (r1_q !== 32'h2891_8000) begin fails++; $display("FAIL ir_r1: got %h exp %h", r1_q, 32'h2891_8000); end
        strobes(0, 0, 0, 0, 1, 0, 0, 1);
        tick();
        if (r0_q !== 32'h2891_8000) begin fails++; $display("FAIL r1_r0: got %h exp %h", r0_q, 32'h2891_8000); end
    endtask

    task automatic test_conflict();
        pc_immediate = 32'd7;
        strobes(1, 0, 0, 0, 0, 0, 0, 0); tick();
        strobes(0, 1, 0, 0, 1, 0, 0, 0); tick();
        pc_immediate = 32'd5;
        strobes(1, 0, 0, 0, 0, 0, 0, 0); tick();
        strobes(0, 1, 0, 0, 0, 1, 0, 0);
        tests += 4;
        if (bus !== 32'd5) begin fails++; $display("FAIL conflict_bus: got %h exp %h", bus, 32'd5); end
        if (bus_conflict !== 1'b1) begin fails++; $display("FAIL conflict_flag: got %b exp 1", bus_conflict); end
        strobes(0, 0, 0, 0, 0, 0, 0, 0);
        if (bus !== 32'd0) begin fails++; $display("FAIL idle_bus: got %h exp 0", bus); end
        if (bus_conflict !== 1'b0) begin fails++; $display("FAIL idle_flag: got %b exp 0", bus_conflict); end
    endtask

    task automatic test_load_and_drive();
        pc_immediate = 32'h0000_00AA;
        strobes(1, 1, 0, 0, 0, 0, 1, 0);
        tests += 3;
        if (bus !== 32'd5) begin fails++; $display("FAIL ld_drv_bus: got %h exp %h", bus, 32'd5); end
        tick();
        if (r1_q !== 32'd5) begin fails++; $display("FAIL ld_drv_r1: got %h exp %h", r1_q, 32'd5); end
        if (pc_q !== 32'h0000_00AA) begin fails++; $display("FAIL ld_drv_pc: got %h exp %h", pc_q, 32'hAA); end
    endtask

    task automatic test_clear_priority();
        pc_immediate = 32'd9;
        clear = 1'b1;
        strobes(1, 0, 0, 0, 1, 0, 0, 0);
        tick();
        clear = 1'b0;
        tests += 3;
        if (pc_q !== 32'h100) begin fails++; $display("FAIL clr_pc: got %h exp %h", pc_q, 32'h100); end
        if (r0_q !== 32'h0) begin fails++; $display("FAIL clr_r0: got %h exp 0", r0_q); end
        if (ir_q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL clr_ir: got %h exp %h", ir_q, 32'hDEAD_BEEF); end
    endtask

    task automatic test_back_to_back_swap();
        logic [WIDTH-1:0] a, b;
        a = $urandom; b = $urandom;
        pc_immediate = a; strobes(1, 0, 0, 0, 0, 0, 0, 0); tick();
        strobes(0, 1, 0, 0, 1, 0, 0, 0); tick();
        pc_immediate = b; strobes(1, 0, 0, 0, 0, 0, 0, 0); tick();
        strobes(0, 1, 0, 0, 0, 0, 1, 0); tick();
        tests += 3;
        strobes(0, 0, 0, 0, 0, 1, 1, 0); tick();
        if (r1_q !== a) begin fails++; $display("FAIL swap1_r1: got %h exp %h", r1_q, a); end
        strobes(0, 0, 0, 0, 1, 0, 0, 1); tick();
        if (r1_q !== a) begin fails++; $display("FAIL swap2_r1: got %h exp %h", r1_q, a); end
        if (r0_q !== a) begin fails++; $display("FAIL swap2_r0: got %h exp %h", r0_q, a); end
    endtask

    task automatic test_random();
        logic [7:0] s;
        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 15) == 0);
            pc = $urandom; ir = $urandom;
            pc_immediate = $urandom; ir_immediate = $urandom;
            s = 8'($urandom);
            strobes(s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]);
            tests += 2;
            if (bus !== model_bus()) begin fails++; $display("FAIL rnd_bus[%0d]: got %h exp %h", i, bus, model_bus()); end
            if (bus_conflict !== model_conflict()) begin
                fails++; $display("FAIL rnd_conflict[%0d]: got %b exp %b", i, bus_conflict, model_conflict());
            end
            tick();
            tests += 4;
            if (pc_q !== m_reg[0]) begin fails++; $display("FAIL rnd_pc[%0d]: got %h exp %h", i, pc_q, m_reg[0]); end
            if (ir_q !== m_reg[1]) begin fails++; $display("FAIL rnd_ir[%0d]: got %h exp %h", i, ir_q, m_reg[1]); end
            if (r0_q !== m_reg[2]) begin fails++; $display("FAIL rnd_r0[%0d]: got %h exp %h", i, r0_q, m_reg[2]); end
            if (r1_q !== m_reg[3]) begin fails++; $display("FAIL rnd_r1[%0d]: got %h exp %h", i, r1_q, m_reg[3]); end
        end
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b0; pc = '0; ir = '0; pc_immediate = '0; ir_immediate = '0;
        pci = 0; pco = 0; iri = 0; iro = 0; r0i = 0; r0o = 0; r1i = 0; r1o = 0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_pc_to_r0();
        test_ir_transfer();
        test_conflict();
        test_load_and_drive();
        test_clear_priority();
        test_back_to_back_swap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
